riscv_i32_coproc_issue: RTL and testbench
=========================================

Name: riscv_i32_coproc_issue

Overview:
Pipeline-side initiator for the coprocessor control/response interface. It accepts decoded coprocessor instructions from a valid/ready source and runs them through a two-slot decode/ALU model. It drives the coproc_controls signals and consumes coproc_response, including the cannot_start / cannot_complete stalls. Completed results are returned on a one-cycle writeback port, so a coprocessor such as riscv_i32_muldiv can be exercised by a real pipeline model rather than a canned harness.

Parameters:
TIMEOUT_CYCLES, 64, consecutive ALU-slot stall cycles (cannot_start or cannot_complete) before the sticky timeout flag is set.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  decode slot can accept (empty, or draining to ALU this cycle)
in_rd / in_op / in_subop  in  5/4/4  destination register, op, subop
in_rs1_data / in_rs2_data  in  32/32  operand values, captured with the instruction
flush  in  1  discard all in-flight instructions
coproc_controls__dec_idecode_valid  out  1  decode slot full
coproc_controls__dec_idecode__rd / __op / __subop  out  5/4/4  decode slot fields; all other dec_idecode fields driven 0 except rd_written=1
coproc_controls__dec_to_alu_blocked  out  1  decode slot cannot advance this cycle
coproc_controls__alu_rs1 / __alu_rs2  out  32/32  ALU slot operands
coproc_controls__alu_flush_pipeline  out  1  flush & (ALU slot full)
coproc_controls__alu_cannot_start / __alu_cannot_complete  out  1/1  feedback: equal to the response bits while the ALU slot is full, else 0
coproc_response__cannot_start / __cannot_complete / __result_valid  in  1/1/1  coprocessor status
coproc_response__result  in  32  result
wb_valid / wb_rd / wb_data  out  1/5/32  registered writeback, one-cycle pulse
err_no_result / err_timeout  out  1/1  sticky error flags

Behaviour:
- Reset (reset_n low at a clk edge) applies to both slots. Both slots empty; all outputs 0 except in_ready=1; stall counter 0; sticky flags cleared. Reset mid-operation drops in-flight work with no writeback.
- Decode slot: loads on in_valid & in_ready. Holds rd/op/subop/rs1/rs2.
- dec_to_alu_blocked = dec_full & (cannot_start | cannot_complete | alu_stalled).
- ALU slot states:
  - EMPTY
  - START: first cycle, or held while cannot_start=1
  - BUSY: started, cannot_complete=1
- Completion is the cycle the ALU slot is full with cannot_start=0 and cannot_complete=0, in state START or BUSY.
  - Next edge: wb_valid=1, wb_rd=slot rd, wb_data=result if result_valid, else 0 and err_no_result set.
- alu_stalled = ALU slot full & !completing.
- Decode slot advances to ALU when dec_full & !dec_to_alu_blocked. ALU slot refill in the completion cycle is permitted, giving back-to-back throughput of 1 per cycle for single-cycle ops.
- in_ready = !dec_full | advancing. Combinational, no in_valid dependency.
- Stall counter:
  - Increments each cycle the ALU slot is full and not completing.
  - Clears on completion, flush, or empty slot.
  - Saturates at TIMEOUT_CYCLES and sets err_timeout. The instruction is not aborted.
- flush:
  - Both slots go empty next edge; no wb_valid for flushed work, even if completing that cycle (flush wins).
  - in_ready=0 during the flush cycle.
  - alu_flush_pipeline is combinational, same cycle.
- Sticky flags clear only on reset.

Decomposition:
- Shared package riscv_coproc_pkg:
  - t_coproc_controls and t_coproc_response structures
  - op/subop constants (muldiv mul/mulh/mulhsu/mulhu/div/divu/rem/remu)
  - ALU-slot state enum
- Sub-module riscv_i32_coproc_stall_timer: saturating counter with clear/enable inputs and sticky timeout output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Single MUL:
  - Stimulus: rs1=7, rs2=6, rd=5; bench coproc answers with no stalls.
  - Response: wb_valid exactly 2 cycles after acceptance, wb_rd=5, wb_data=42.
- DIV with cannot_complete:
  - Stimulus: rs1=100, rs2=7; cannot_complete held for 10 cycles.
  - Response: wb_data=14 on the cycle after the stall drops; dec_to_alu_blocked=1 throughout; a second queued instruction stays in decode.
- cannot_start held 3 cycles:
  - Response: alu_rs1/rs2 stable; in_ready=0 while both slots are full; no wb until release.
- Flush in the completion cycle:
  - Response: no wb_valid; both slots empty; alu_flush_pipeline=1 that cycle; next instruction accepted next cycle.
- Timeout:
  - Stimulus: cannot_complete held 64 cycles.
  - Response: err_timeout=1 at cycle 64 and stays set after completion.
- Missing result:
  - Stimulus: completion with result_valid=0.
  - Response: wb_data=0; err_no_result=1.
- Reset:
  - Stimulus: reset_n low while BUSY.
  - Response: no wb; all flags 0; in_ready=1.

Source files
------------

// File: rtl/riscv_coproc_pkg.sv
// Shared types and constants for the pipeline-side coprocessor issue logic.
package riscv_coproc_pkg;

    // Major opcode carried by coprocessor instructions and the muldiv subop codes.
    localparam logic [3:0] OpMuldiv    = 4'd3;
    localparam logic [3:0] SubopMul    = 4'd0;
    localparam logic [3:0] SubopMulh   = 4'd1;
    localparam logic [3:0] SubopMulhsu = 4'd2;
    localparam logic [3:0] SubopMulhu  = 4'd3;
    localparam logic [3:0] SubopDiv    = 4'd4;
    localparam logic [3:0] SubopDivu   = 4'd5;
    localparam logic [3:0] SubopRem    = 4'd6;
    localparam logic [3:0] SubopRemu   = 4'd7;

    // ALU-slot occupancy: Start covers the first cycle and any cannot_start hold,
    // Busy means the coprocessor has started but is still reporting cannot_complete.
    typedef enum logic [1:0] {
        AluEmpty = 2'd0,
        AluStart = 2'd1,
        AluBusy  = 2'd2
    } t_alu_state;

    // Decode-stage view handed to the coprocessor.
    typedef struct packed {
        logic [4:0] rd;
        logic       rd_written;
        logic [3:0] op;
        logic [3:0] subop;
    } t_idecode;

    // Full control bundle as seen by a coprocessor.
    typedef struct packed {
        logic        dec_idecode_valid;
        t_idecode    dec_idecode;
        logic        dec_to_alu_blocked;
        logic [31:0] alu_rs1;
        logic [31:0] alu_rs2;
        logic        alu_flush_pipeline;
        logic        alu_cannot_start;
        logic        alu_cannot_complete;
    } t_coproc_controls;

    // Status returned by the coprocessor.
    typedef struct packed {
        logic        cannot_start;
        logic        cannot_complete;
        logic        result_valid;
        logic [31:0] result;
    } t_coproc_response;

    // Contents of the decode slot; operands travel with the instruction.
    typedef struct packed {
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [3:0]  subop;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } t_dec_slot;

endpackage

// File: rtl/riscv_i32_coproc_stall_timer.sv
// Saturating stall counter with a sticky timeout flag.
module riscv_i32_coproc_stall_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned CountWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CountWidth-1:0] Limit = CountWidth'(TIMEOUT_CYCLES);

    logic [CountWidth-1:0] count_q, count_d;
    logic                  timeout_q, timeout_d;

    // Next count: clear wins over enable; hold once the limit is reached.
    always_comb begin
        count_d   = count_q;
        timeout_d = timeout_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
        if (count_d == Limit) begin
            timeout_d = 1'b1;
        end
    end

    // Counter and sticky flag registers; only reset clears the flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/riscv_i32_coproc_issue.sv
// Pipeline-side initiator: two-slot decode/ALU model driving a coprocessor
// control/response interface, with a registered one-cycle writeback port.
module riscv_i32_coproc_issue
    import riscv_coproc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_subop,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        flush,

    output logic        coproc_controls__dec_idecode_valid,
    output logic [4:0]  coproc_controls__dec_idecode__rd,
    output logic [3:0]  coproc_controls__dec_idecode__op,
    output logic [3:0]  coproc_controls__dec_idecode__subop,
    output logic        coproc_controls__dec_to_alu_blocked,
    output logic [31:0] coproc_controls__alu_rs1,
    output logic [31:0] coproc_controls__alu_rs2,
    output logic        coproc_controls__alu_flush_pipeline,
    output logic        coproc_controls__alu_cannot_start,
    output logic        coproc_controls__alu_cannot_complete,

    input  logic        coproc_response__cannot_start,
    input  logic        coproc_response__cannot_complete,
    input  logic        coproc_response__result_valid,
    input  logic [31:0] coproc_response__result,

    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_no_result,
    output logic        err_timeout
);

    t_coproc_response rsp;

    t_dec_slot   dec_q, dec_d;
    logic        dec_full_q, dec_full_d;
    t_alu_state  alu_state_q, alu_state_d;
    logic [4:0]  alu_rd_q, alu_rd_d;
    logic [31:0] alu_rs1_q, alu_rs1_d;
    logic [31:0] alu_rs2_q, alu_rs2_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_no_result_q, err_no_result_d;

    logic alu_full;
    logic alu_cs;
    logic alu_cc;
    logic completing;
    logic alu_stalled;
    logic dec_blocked;
    logic advancing;
    logic accept;

    assign rsp = '{
        cannot_start:    coproc_response__cannot_start,
        cannot_complete: coproc_response__cannot_complete,
        result_valid:    coproc_response__result_valid,
        result:          coproc_response__result
    };

    // Slot handshake: response bits only matter while the ALU slot holds work.
    always_comb begin
        alu_full    = (alu_state_q != AluEmpty);
        alu_cs      = alu_full & rsp.cannot_start;
        alu_cc      = alu_full & rsp.cannot_complete;
        completing  = alu_full & ~alu_cs & ~alu_cc;
        alu_stalled = alu_full & ~completing;
        dec_blocked = dec_full_q & (alu_cs | alu_cc | alu_stalled);
        advancing   = dec_full_q & ~dec_blocked;
        in_ready    = ~flush & (~dec_full_q | advancing);
        accept      = in_valid & in_ready;
    end

    // Slot next-state: flush empties both; the ALU may refill in its completion cycle.
    always_comb begin
        dec_d       = dec_q;
        dec_full_d  = dec_full_q;
        alu_state_d = alu_state_q;
        alu_rd_d    = alu_rd_q;
        alu_rs1_d   = alu_rs1_q;
        alu_rs2_d   = alu_rs2_q;
        if (flush) begin
            dec_full_d  = 1'b0;
            alu_state_d = AluEmpty;
        end else begin
            if (advancing) begin
                alu_state_d = AluStart;
                alu_rd_d    = dec_q.rd;
                alu_rs1_d   = dec_q.rs1;
                alu_rs2_d   = dec_q.rs2;
            end else if (completing) begin
                alu_state_d = AluEmpty;
            end else if (alu_cc && !alu_cs) begin
                // Started but not finished; Busy persists until completion.
                alu_state_d = AluBusy;
            end
            if (accept) begin
                dec_full_d = 1'b1;
                dec_d      = '{rd: in_rd, op: in_op, subop: in_subop,
                               rs1: in_rs1_data, rs2: in_rs2_data};
            end else if (advancing) begin
                dec_full_d = 1'b0;
            end
        end
    end

    // Writeback next-state: a completion suppressed by flush produces nothing.
    always_comb begin
        wb_valid_d      = completing & ~flush;
        wb_rd_d         = wb_valid_d ? alu_rd_q : 5'd0;
        wb_data_d       = (wb_valid_d && rsp.result_valid) ? rsp.result : 32'd0;
        err_no_result_d = err_no_result_q | (wb_valid_d & ~rsp.result_valid);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dec_q           <= '0;
            dec_full_q      <= 1'b0;
            alu_state_q     <= AluEmpty;
            alu_rd_q        <= '0;
            alu_rs1_q       <= '0;
            alu_rs2_q       <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            err_no_result_q <= 1'b0;
        end else begin
            dec_q           <= dec_d;
            dec_full_q      <= dec_full_d;
            alu_state_q     <= alu_state_d;
            alu_rd_q        <= alu_rd_d;
            alu_rs1_q       <= alu_rs1_d;
            alu_rs2_q       <= alu_rs2_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            err_no_result_q <= err_no_result_d;
        end
    end

    riscv_i32_coproc_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (completing | flush | ~alu_full),
        .enable  (alu_stalled),
        .timeout (err_timeout)
    );

    // Coprocessor-facing controls; empty slots present zeros.
    always_comb begin
        coproc_controls__dec_idecode_valid   = dec_full_q;
        coproc_controls__dec_idecode__rd     = dec_full_q ? dec_q.rd : 5'd0;
        coproc_controls__dec_idecode__op     = dec_full_q ? dec_q.op : 4'd0;
        coproc_controls__dec_idecode__subop  = dec_full_q ? dec_q.subop : 4'd0;
        coproc_controls__dec_to_alu_blocked  = dec_blocked;
        coproc_controls__alu_rs1             = alu_full ? alu_rs1_q : 32'd0;
        coproc_controls__alu_rs2             = alu_full ? alu_rs2_q : 32'd0;
        coproc_controls__alu_flush_pipeline  = flush & alu_full;
        coproc_controls__alu_cannot_start    = alu_cs;
        coproc_controls__alu_cannot_complete = alu_cc;
    end

    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign err_no_result = err_no_result_q;

endmodule

// File: tb/tb_riscv_i32_coproc_issue.sv
// Bench for riscv_i32_coproc_issue: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_riscv_i32_coproc_issue;
    import riscv_coproc_pkg::*;

    localparam int unsigned T = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, in_valid, in_ready, flush;
    logic [4:0]  in_rd;
    logic [3:0]  in_op, in_subop;
    logic [31:0] in_rs1_data, in_rs2_data;
    logic        dec_valid, blocked, alu_flush, alu_cs_fb, alu_cc_fb;
    logic [4:0]  dec_rd;
    logic [3:0]  dec_op, dec_subop;
    logic [31:0] alu_rs1, alu_rs2;
    logic        rsp_cs, rsp_cc, rsp_rv;
    logic [31:0] rsp_result;
    logic        wb_valid, err_no_result, err_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    riscv_i32_coproc_issue #(.TIMEOUT_CYCLES(T)) dut (
        .clk                                  (clk),
        .reset_n                              (reset_n),
        .in_valid                             (in_valid),
        .in_ready                             (in_ready),
        .in_rd                                (in_rd),
        .in_op                                (in_op),
        .in_subop                             (in_subop),
        .in_rs1_data                          (in_rs1_data),
        .in_rs2_data                          (in_rs2_data),
        .flush                                (flush),
        .coproc_controls__dec_idecode_valid   (dec_valid),
        .coproc_controls__dec_idecode__rd     (dec_rd),
        .coproc_controls__dec_idecode__op     (dec_op),
        .coproc_controls__dec_idecode__subop  (dec_subop),
        .coproc_controls__dec_to_alu_blocked  (blocked),
        .coproc_controls__alu_rs1             (alu_rs1),
        .coproc_controls__alu_rs2             (alu_rs2),
        .coproc_controls__alu_flush_pipeline  (alu_flush),
        .coproc_controls__alu_cannot_start    (alu_cs_fb),
        .coproc_controls__alu_cannot_complete (alu_cc_fb),
        .coproc_response__cannot_start        (rsp_cs),
        .coproc_response__cannot_complete     (rsp_cc),
        .coproc_response__result_valid        (rsp_rv),
        .coproc_response__result              (rsp_result),
        .wb_valid                             (wb_valid),
        .wb_rd                                (wb_rd),
        .wb_data                              (wb_data),
        .err_no_result                        (err_no_result),
        .err_timeout                          (err_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // In-flight instructions oldest first; the head sits in the ALU slot when
    // head_in_alu is set, any other entry is in the decode slot.
    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [3:0]  subop;
        logic [31:0] a;
        logic [31:0] b;
    } instr_t;

    instr_t      pipe[$];
    bit          head_in_alu = 0;
    int          stall_cnt   = 0;
    bit          m_wb = 0, m_err_nr = 0, m_err_to = 0;
    logic [4:0]  m_wb_rd   = 0;
    logic [31:0] m_wb_data = 0;
    bit          armed = 0;

    always @(negedge clk) begin
        bit          a_full, d_full, stl, cmp, rdy;
        int          di;
        logic [31:0] e_drd, e_dop, e_dsub, e_rs1, e_rs2;
        instr_t      ni;

        a_full = head_in_alu;
        d_full = pipe.size() > (a_full ? 1 : 0);
        stl    = a_full && (rsp_cs || rsp_cc);
        cmp    = a_full && !stl;
        rdy    = !flush && (!d_full || !stl);
        e_drd = 0; e_dop = 0; e_dsub = 0; e_rs1 = 0; e_rs2 = 0;
        if (d_full) begin
            di     = a_full ? 1 : 0;
            e_drd  = 32'(pipe[di].rd);
            e_dop  = 32'(pipe[di].op);
            e_dsub = 32'(pipe[di].subop);
        end
        if (a_full) begin
            e_rs1 = pipe[0].a;
            e_rs2 = pipe[0].b;
        end

        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("dec_valid", 32'(dec_valid), 32'(d_full));
            chk("dec_rd", 32'(dec_rd), e_drd);
            chk("dec_op", 32'(dec_op), e_dop);
            chk("dec_subop", 32'(dec_subop), e_dsub);
            chk("dec_blocked", 32'(blocked), 32'(d_full && stl));
            chk("alu_rs1", alu_rs1, e_rs1);
            chk("alu_rs2", alu_rs2, e_rs2);
            chk("alu_flush", 32'(alu_flush), 32'(flush && a_full));
            chk("alu_cs_fb", 32'(alu_cs_fb), 32'(a_full && rsp_cs));
            chk("alu_cc_fb", 32'(alu_cc_fb), 32'(a_full && rsp_cc));
            chk("wb_valid", 32'(wb_valid), 32'(m_wb));
            chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
            chk("wb_data", wb_data, m_wb_data);
            chk("err_no_result", 32'(err_no_result), 32'(m_err_nr));
            chk("err_timeout", 32'(err_timeout), 32'(m_err_to));
        end

        // Advance to what the next clock edge produces.
        if (!reset_n) begin
            pipe.delete();
            head_in_alu = 0; stall_cnt = 0;
            m_wb = 0; m_wb_rd = 0; m_wb_data = 0; m_err_nr = 0; m_err_to = 0;
            armed = 1;
        end else if (flush) begin
            pipe.delete();
            head_in_alu = 0; stall_cnt = 0;
            m_wb = 0; m_wb_rd = 0; m_wb_data = 0;
        end else begin
            m_wb      = cmp;
            m_wb_rd   = cmp ? pipe[0].rd : 5'd0;
            m_wb_data = (cmp && rsp_rv) ? rsp_result : 32'd0;
            if (cmp && !rsp_rv) m_err_nr = 1;
            if (stl) begin
                if (stall_cnt < int'(T)) stall_cnt++;
                if (stall_cnt == int'(T)) m_err_to = 1;
            end else begin
                stall_cnt = 0;
            end
            if (cmp) pipe.delete(0);
            // ALU stays occupied if stalled, otherwise a waiting entry moves in.
            head_in_alu = stl || d_full;
            if (in_valid && rdy) begin
                ni.rd = in_rd; ni.op = in_op; ni.subop = in_subop;
                ni.a = in_rs1_data; ni.b = in_rs2_data;
                pipe.push_back(ni);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [3:0] subop,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_rd = rd; in_op = OpMuldiv; in_subop = subop;
        in_rs1_data = a; in_rs2_data = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        in_rd = '0; in_op = '0; in_subop = '0; in_rs1_data = '0; in_rs2_data = '0;
        rsp_cs = 1'b0; rsp_cc = 1'b0; rsp_rv = 1'b0; rsp_result = '0;
        step(); step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_errs", {30'd0, err_no_result, err_timeout}, 32'd0);

        // Single MUL 7*6 into x5: writeback two edges after acceptance.
        step(); offer(5'd5, SubopMul, 32'd7, 32'd6); rsp_rv = 1'b1; rsp_result = 32'd42;
        step(); in_valid = 1'b0;
        @(negedge clk); chk("t1_dec_rd", 32'(dec_rd), 32'd5);
        step();
        @(negedge clk); chk("t1_alu_rs1", alu_rs1, 32'd7); chk("t1_wb_early", 32'(wb_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_wb_valid", 32'(wb_valid), 32'd1);
        chk("t1_wb_rd", 32'(wb_rd), 32'd5);
        chk("t1_wb_data", wb_data, 32'd42);
        step();
        @(negedge clk); chk("t1_wb_pulse", 32'(wb_valid), 32'd0);

        // DIVU 100/7 with cannot_complete for 10 cycles; MUL 3*4 waits in decode.
        step(); offer(5'd3, SubopDivu, 32'd100, 32'd7); rsp_result = 32'd14;
        step(); offer(5'd9, SubopMul, 32'd3, 32'd4); rsp_cc = 1'b1;
        @(negedge clk); chk("t2_in_ready", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_blocked", 32'(blocked), 32'd1);
            chk("t2_dec_rd", 32'(dec_rd), 32'd9);
            step();
        end
        rsp_cc = 1'b0;
        @(negedge clk); chk("t2_no_wb", 32'(wb_valid), 32'd0);
        step(); rsp_result = 32'd12;
        @(negedge clk); chk("t2_wb_rd", 32'(wb_rd), 32'd3); chk("t2_wb_data", wb_data, 32'd14);
        step();
        @(negedge clk); chk("t2_wb2_rd", 32'(wb_rd), 32'd9); chk("t2_wb2_data", wb_data, 32'd12);

        // MULHU 0xffffffff*2 held by cannot_start for 3 cycles; REMU 17%5 behind it.
        step(); offer(5'd4, SubopMulhu, 32'hFFFF_FFFF, 32'd2); rsp_result = 32'd1;
        step(); offer(5'd6, SubopRemu, 32'd17, 32'd5); rsp_cs = 1'b1;
        step(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_alu_rs1", alu_rs1, 32'hFFFF_FFFF);
            chk("t3_alu_rs2", alu_rs2, 32'd2);
            chk("t3_in_ready", 32'(in_ready), 32'd0);
            chk("t3_no_wb", 32'(wb_valid), 32'd0);
            step();
        end
        rsp_cs = 1'b0;
        step(); rsp_result = 32'd2;
        @(negedge clk); chk("t3_wb_rd", 32'(wb_rd), 32'd4); chk("t3_wb_data", wb_data, 32'd1);
        step();
        @(negedge clk); chk("t3_wb2_rd", 32'(wb_rd), 32'd6); chk("t3_wb2_data", wb_data, 32'd2);

        // Flush in the completion cycle of MUL 2*3; next instruction taken one cycle later.
        step(); offer(5'd7, SubopMul, 32'd2, 32'd3); rsp_result = 32'd6;
        step(); in_valid = 1'b0;
        step(); flush = 1'b1; offer(5'd8, SubopMul, 32'd5, 32'd5);
        @(negedge clk); chk("t4_alu_flush", 32'(alu_flush), 32'd1); chk("t4_in_ready", 32'(in_ready), 32'd0);
        step(); flush = 1'b0; rsp_result = 32'd25;
        @(negedge clk);
        chk("t4_no_wb", 32'(wb_valid), 32'd0);
        chk("t4_dec_empty", 32'(dec_valid), 32'd0);
        chk("t4_alu_empty", alu_rs1, 32'd0);
        chk("t4_in_ready_after", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        step(); step();
        @(negedge clk); chk("t4_wb_rd", 32'(wb_rd), 32'd8); chk("t4_wb_data", wb_data, 32'd25);

        // Completion without result_valid.
        step(); offer(5'd10, SubopMul, 32'd9, 32'd9); rsp_rv = 1'b0; rsp_result = 32'hDEAD_BEEF;
        step(); in_valid = 1'b0;
        step();
        @(negedge clk); chk("t5_err_before", 32'(err_no_result), 32'd0);
        step();
        @(negedge clk);
        chk("t5_wb_valid", 32'(wb_valid), 32'd1);
        chk("t5_wb_rd", 32'(wb_rd), 32'd10);
        chk("t5_wb_data", wb_data, 32'd0);
        chk("t5_err", 32'(err_no_result), 32'd1);

        // DIVU 50/5 held 64+ cycles by cannot_complete.
        step(); offer(5'd11, SubopDivu, 32'd50, 32'd5); rsp_rv = 1'b1; rsp_result = 32'd10;
        step(); in_valid = 1'b0; rsp_cc = 1'b1;
        step();
        repeat (63) step();
        @(negedge clk); chk("t6_to_63", 32'(err_timeout), 32'd0);
        step();
        @(negedge clk); chk("t6_to_64", 32'(err_timeout), 32'd1); chk("t6_no_wb", 32'(wb_valid), 32'd0);
        step(); rsp_cc = 1'b0;
        step();
        @(negedge clk);
        chk("t6_wb_data", wb_data, 32'd10);
        chk("t6_to_kept", 32'(err_timeout), 32'd1);

        // Reset while Busy drops the instruction and clears sticky flags.
        step(); offer(5'd12, SubopMul, 32'd1, 32'd1); rsp_result = 32'd1;
        step(); in_valid = 1'b0; rsp_cc = 1'b1;
        step(); step(); step();
        @(negedge clk); chk("t7_nr_set", 32'(err_no_result), 32'd1); chk("t7_to_set", 32'(err_timeout), 32'd1);
        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1; rsp_cc = 1'b0;
        @(negedge clk);
        chk("t7_wb", 32'(wb_valid), 32'd0);
        chk("t7_errs", {30'd0, err_no_result, err_timeout}, 32'd0);
        chk("t7_in_ready", 32'(in_ready), 32'd1);
        chk("t7_dec_valid", 32'(dec_valid), 32'd0);
        step();
        @(negedge clk); chk("t7_no_late_wb", 32'(wb_valid), 32'd0);

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
